cam_frame_ctrl: RTL and testbench
=================================

Name: cam_frame_ctrl

Overview:
Camera-side controller between the image-sensor pads and the internal pixel consumer (UART streamer / frame buffer).
- Runs the sensor power-up sequence (PWDN, RESET, settle) and generates XCLK from MCLK.
- On a capture request, waits for frame start and extracts a rectangular byte window from one frame onto a valid/ready stream.
- Everything runs in the MCLK domain; camera sync/pixel inputs are oversampled.

Parameters:
XCLK_DIV, 2, MCLK cycles per XCLK half-period (>=1)
PWDN_CYC, 1000, MCLK cycles in power-down state
RST_CYC, 1000, MCLK cycles with sensor reset asserted
SETTLE_CYC, 10000, MCLK cycles after reset release before ready
LINE_START, 0, first captured line (0-based, counted per frame)
LINE_COUNT, 480, number of captured lines (>=1)
BYTE_START, 0, first captured byte within a line (0-based)
BYTE_COUNT, 1280, bytes captured per line (>=1)

Ports:
xipMCLK  in  1  system clock
xipRESET  in  1  asynchronous reset, active-high
iCAPTURE  in  1  one-cycle capture request
iCAM_VSYNC  in  1  sensor VSYNC (async)
iCAM_HREF  in  1  sensor HREF (async)
iCAM_PCLK  in  1  sensor pixel clock (async, <= MCLK/4)
iCAM_D  in  8  sensor data (async)
oCAM_PWDN  out  1  sensor power-down
onCAM_RESET  out  1  sensor reset, active-low
oCAM_XCLK  out  1  sensor clock
oDATA  out  8  captured byte
oVALID  out  1  oDATA valid
iREADY  in  1  consumer accepts
oLINE_END  out  1  1-cycle pulse at end of each window line
oFRAME_END  out  1  1-cycle pulse at end of capture
oCAM_RDY  out  1  power-up sequence complete
oBUSY  out  1  in WAIT_VS or CAPTURE
oOVERFLOW  out  1  sticky: byte dropped
oTRUNC  out  1  sticky: VSYNC ended frame before window complete
oSTATE  out  3  current state

Behaviour:
- Reset values:
  - All outputs 0, except oCAM_PWDN=1.
  - onCAM_RESET=0; oSTATE=0 (PWDN).
  - All counters and synchronizers are cleared.
  - Reset mid-capture aborts immediately and restarts the power-up sequence.
- State encoding: PWDN=0, RST=1, SETTLE=2, IDLE=3, WAIT_VS=4, CAPTURE=5, DONE=6.
- Power-up sequence:
  - PWDN: PWDN=1, nRESET=0, for PWDN_CYC cycles.
  - RST: PWDN=0, nRESET=0, for RST_CYC cycles.
  - SETTLE: nRESET=1, for SETTLE_CYC cycles.
  - Then IDLE. oCAM_RDY=1 from IDLE onward, until reset.
  - Each state's cycle counter is 16-bit and reloads on state entry.
- XCLK: held 0 in PWDN; toggles every XCLK_DIV MCLK cycles in all other states; free-running, never gated by capture.
- Input path:
  - VSYNC, HREF, PCLK and D each pass through a 2-FF synchronizer; a third FF feeds edge detect.
  - PCLK rise = synced high and previous low; D is sampled from the same synchronizer stage as the PCLK edge.
  - Latency: a byte appears on oDATA/oVALID 4 MCLK edges after the first edge that samples PCLK high at the pin.
- IDLE:
  - iCAPTURE clears oOVERFLOW and oTRUNC, then -> WAIT_VS.
  - iCAPTURE in any other state is ignored.
- WAIT_VS: synced VSYNC falling edge -> CAPTURE, with line counter = 0 and byte counter = 0.
- CAPTURE counters:
  - Byte counter (11-bit): cleared on HREF rise; increments on each PCLK rise while HREF is high.
  - Line counter (10-bit): increments on each HREF fall.
- CAPTURE window:
  - A byte is in-window when line is in [LINE_START, LINE_START+LINE_COUNT) and byte is in [BYTE_START, BYTE_START+BYTE_COUNT).
  - Counters saturate at their maximum value, with no wrap.
- Output register:
  - An in-window byte loads oDATA and sets oVALID when oVALID=0, or when oVALID=1 and iREADY=1 in the same cycle.
  - In the remaining case (oVALID=1, iREADY=0), the new byte is dropped and oOVERFLOW is set.
  - oVALID clears on iREADY when no new byte loads.
  - oDATA is stable while oVALID=1 and iREADY=0.
- End conditions:
  - HREF fall on an in-window line pulses oLINE_END.
  - If that line is LINE_START+LINE_COUNT-1 -> DONE.
  - Synced VSYNC rise in CAPTURE before the last line -> DONE and set oTRUNC.
  - If both occur in the same cycle, HREF completion wins (no oTRUNC).
- DONE: one cycle, oFRAME_END=1, -> IDLE.
  - A pending oVALID byte stays until accepted; it is not flushed or dropped.
- oBUSY = (state==WAIT_VS) || (state==CAPTURE).

Test Plan:
Common bench setup: PWDN_CYC=4, RST_CYC=4, SETTLE_CYC=8, XCLK_DIV=2, LINE_START=1, LINE_COUNT=2, BYTE_START=2, BYTE_COUNT=3. Sensor model: 4 lines x 6 bytes, D=line*16+byte, PCLK=MCLK/8.
1. Power-up: release xipRESET -> PWDN=1 for 4 cycles; then PWDN=0/nRESET=0 for 4 cycles; nRESET=1 for 8 cycles; then oCAM_RDY=1, oSTATE=3. XCLK period = 4 MCLK after PWDN.
2. Capture with iREADY=1 -> stream 0x12,0x13,0x14,0x22,0x23,0x24. oLINE_END pulses twice, then oFRAME_END once. oOVERFLOW=0, oTRUNC=0, back to IDLE.
3. Backpressure: iREADY=0 throughout line 1 -> only 0x12 is held on oDATA. oOVERFLOW=1, sticky until the next iCAPTURE in IDLE.
4. Truncation: sensor drives VSYNC high after line 1 -> outputs 0x12,0x13,0x14; then oFRAME_END with oTRUNC=1.
5. iCAPTURE asserted during SETTLE and during CAPTURE -> ignored; oSTATE is unchanged and no second capture occurs.
6. xipRESET pulsed mid-CAPTURE -> oVALID=0, oSTATE=0, oCAM_PWDN=1, and the full power-up sequence repeats.

Source files
------------

// File: rtl/cam_frame_ctrl.sv
// Camera-side controller: sensor power-up sequencing, XCLK generation and
// single-frame window capture onto a valid/ready byte stream, all in the MCLK domain.
module cam_frame_ctrl #(
   parameter int XCLK_DIV   = 2,
   parameter int PWDN_CYC   = 1000,
   parameter int RST_CYC    = 1000,
   parameter int SETTLE_CYC = 10000,
   parameter int LINE_START = 0,
   parameter int LINE_COUNT = 480,
   parameter int BYTE_START = 0,
   parameter int BYTE_COUNT = 1280
) (
   input  logic       xipMCLK,
   input  logic       xipRESET,
   input  logic       iCAPTURE,
   input  logic       iCAM_VSYNC,
   input  logic       iCAM_HREF,
   input  logic       iCAM_PCLK,
   input  logic [7:0] iCAM_D,
   output logic       oCAM_PWDN,
   output logic       onCAM_RESET,
   output logic       oCAM_XCLK,
   output logic [7:0] oDATA,
   output logic       oVALID,
   input  logic       iREADY,
   output logic       oLINE_END,
   output logic       oFRAME_END,
   output logic       oCAM_RDY,
   output logic       oBUSY,
   output logic       oOVERFLOW,
   output logic       oTRUNC,
   output logic [2:0] oSTATE
);

   localparam logic [2:0] ST_PWDN    = 3'd0;
   localparam logic [2:0] ST_RST     = 3'd1;
   localparam logic [2:0] ST_SETTLE  = 3'd2;
   localparam logic [2:0] ST_IDLE    = 3'd3;
   localparam logic [2:0] ST_WAIT_VS = 3'd4;
   localparam logic [2:0] ST_CAPTURE = 3'd5;
   localparam logic [2:0] ST_DONE    = 3'd6;

   localparam logic [10:0] LINE_LO   = 11'(LINE_START);
   localparam logic [10:0] LINE_HI   = 11'(LINE_START + LINE_COUNT);
   localparam logic [10:0] LINE_LAST = 11'(LINE_START + LINE_COUNT - 1);
   localparam logic [11:0] BYTE_LO   = 12'(BYTE_START);
   localparam logic [11:0] BYTE_HI   = 12'(BYTE_START + BYTE_COUNT);

   logic [2:0]  state;
   logic [15:0] seqCnt;
   logic [15:0] xclkCnt;
   logic        xclkReg;

   logic [2:0]  vsSync;
   logic [2:0]  hrefSync;
   logic [2:0]  pclkSync;
   logic [7:0]  dSync1;
   logic [7:0]  dSync2;

   logic        pixRise;
   logic [7:0]  pixData;
   logic        hrefLvl;
   logic        hrefRise;
   logic        hrefFall;
   logic        vsRise;
   logic        vsFall;

   logic [9:0]  lineCnt;
   logic [10:0] byteCnt;
   logic        lineInWin;
   logic        byteInWin;
   logic        loadByte;

   logic [7:0]  dataReg;
   logic        validReg;
   logic        lineEndReg;
   logic        overflowReg;
   logic        truncReg;

   // Two-stage synchronizers with a third stage for edge detection; data is
   // taken from the same stage that the PCLK edge is detected on.
   always_ff @(posedge xipMCLK or posedge xipRESET) begin
      if (xipRESET) begin
         vsSync   <= '0;
         hrefSync <= '0;
         pclkSync <= '0;
         dSync1   <= '0;
         dSync2   <= '0;
      end else begin
         vsSync   <= {vsSync[1:0], iCAM_VSYNC};
         hrefSync <= {hrefSync[1:0], iCAM_HREF};
         pclkSync <= {pclkSync[1:0], iCAM_PCLK};
         dSync1   <= iCAM_D;
         dSync2   <= dSync1;
      end
   end

   // Registered sync events so every decision in the capture logic sees the
   // pixel strobe, its data and the HREF/VSYNC edges aligned in one cycle.
   always_ff @(posedge xipMCLK or posedge xipRESET) begin
      if (xipRESET) begin
         pixRise  <= 1'b0;
         pixData  <= '0;
         hrefLvl  <= 1'b0;
         hrefRise <= 1'b0;
         hrefFall <= 1'b0;
         vsRise   <= 1'b0;
         vsFall   <= 1'b0;
      end else begin
         pixRise  <= pclkSync[1] & ~pclkSync[2];
         pixData  <= dSync2;
         hrefLvl  <= hrefSync[1];
         hrefRise <= hrefSync[1] & ~hrefSync[2];
         hrefFall <= ~hrefSync[1] & hrefSync[2];
         vsRise   <= vsSync[1] & ~vsSync[2];
         vsFall   <= ~vsSync[1] & vsSync[2];
      end
   end

   assign lineInWin = ({1'b0, lineCnt} >= LINE_LO) && ({1'b0, lineCnt} < LINE_HI);
   assign byteInWin = ({1'b0, byteCnt} >= BYTE_LO) && ({1'b0, byteCnt} < BYTE_HI);
   assign loadByte  = (state == ST_CAPTURE) && pixRise && hrefLvl && lineInWin && byteInWin;

   // XCLK runs freely in every state except power-down.
   always_ff @(posedge xipMCLK or posedge xipRESET) begin
      if (xipRESET) begin
         xclkCnt <= '0;
         xclkReg <= 1'b0;
      end else if (state == ST_PWDN) begin
         xclkCnt <= '0;
         xclkReg <= 1'b0;
      end else if (xclkCnt == 16'(XCLK_DIV - 1)) begin
         xclkCnt <= '0;
         xclkReg <= ~xclkReg;
      end else begin
         xclkCnt <= xclkCnt + 16'd1;
      end
   end

   // Main sequencer: power-up timing, capture window tracking and the
   // single-entry output register with overflow detection.
   always_ff @(posedge xipMCLK or posedge xipRESET) begin
      if (xipRESET) begin
         state       <= ST_PWDN;
         seqCnt      <= 16'(PWDN_CYC - 1);
         lineCnt     <= '0;
         byteCnt     <= '0;
         dataReg     <= '0;
         validReg    <= 1'b0;
         lineEndReg  <= 1'b0;
         overflowReg <= 1'b0;
         truncReg    <= 1'b0;
      end else begin
         lineEndReg <= 1'b0;
         case (state)
            ST_PWDN: begin
               if (seqCnt == 16'd0) begin
                  state  <= ST_RST;
                  seqCnt <= 16'(RST_CYC - 1);
               end else begin
                  seqCnt <= seqCnt - 16'd1;
               end
            end
            ST_RST: begin
               if (seqCnt == 16'd0) begin
                  state  <= ST_SETTLE;
                  seqCnt <= 16'(SETTLE_CYC - 1);
               end else begin
                  seqCnt <= seqCnt - 16'd1;
               end
            end
            ST_SETTLE: begin
               if (seqCnt == 16'd0) begin
                  state <= ST_IDLE;
               end else begin
                  seqCnt <= seqCnt - 16'd1;
               end
            end
            ST_IDLE: begin
               if (iCAPTURE) begin
                  overflowReg <= 1'b0;
                  truncReg    <= 1'b0;
                  state       <= ST_WAIT_VS;
               end
            end
            ST_WAIT_VS: begin
               if (vsFall) begin
                  lineCnt <= '0;
                  byteCnt <= '0;
                  state   <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (hrefRise) begin
                  byteCnt <= '0;
               end else if (pixRise && hrefLvl && (byteCnt != '1)) begin
                  byteCnt <= byteCnt + 11'd1;
               end
               if (hrefFall) begin
                  if (lineCnt != '1) begin
                     lineCnt <= lineCnt + 10'd1;
                  end
                  if (lineInWin) begin
                     lineEndReg <= 1'b1;
                  end
               end
               // Completing the last window line takes priority over a VSYNC rise.
               if (hrefFall && ({1'b0, lineCnt} == LINE_LAST)) begin
                  state <= ST_DONE;
               end else if (vsRise) begin
                  state    <= ST_DONE;
                  truncReg <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state  <= ST_PWDN;
               seqCnt <= 16'(PWDN_CYC - 1);
            end
         endcase

         if (loadByte) begin
            if (!validReg || iREADY) begin
               dataReg  <= pixData;
               validReg <= 1'b1;
            end else begin
               overflowReg <= 1'b1;
            end
         end else if (iREADY) begin
            validReg <= 1'b0;
         end
      end
   end

   assign oCAM_PWDN   = (state == ST_PWDN);
   assign onCAM_RESET = (state != ST_PWDN) && (state != ST_RST);
   assign oCAM_XCLK   = xclkReg;
   assign oDATA       = dataReg;
   assign oVALID      = validReg;
   assign oLINE_END   = lineEndReg;
   assign oFRAME_END  = (state == ST_DONE);
   assign oCAM_RDY    = (state == ST_IDLE) || (state == ST_WAIT_VS) ||
                        (state == ST_CAPTURE) || (state == ST_DONE);
   assign oBUSY       = (state == ST_WAIT_VS) || (state == ST_CAPTURE);
   assign oOVERFLOW   = overflowReg;
   assign oTRUNC      = truncReg;
   assign oSTATE      = state;

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Scoreboard bench for cam_frame_ctrl: a 4x6 sensor model drives frames while
// expected window bytes are queued and compared as the stream hands them over.
module tb_cam_frame_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       iCAPTURE = 1'b0;
   logic       iCAM_VSYNC = 1'b1;
   logic       iCAM_HREF = 1'b0;
   logic       iCAM_PCLK = 1'b0;
   logic [7:0] iCAM_D = 8'h00;
   logic       iREADY = 1'b1;
   logic       oCAM_PWDN, onCAM_RESET, oCAM_XCLK, oVALID, oLINE_END, oFRAME_END;
   logic       oCAM_RDY, oBUSY, oOVERFLOW, oTRUNC;
   logic [7:0] oDATA;
   logic [2:0] oSTATE;

   int         testsRun = 0;
   int         testsFailed = 0;
   int         lineEndCnt = 0;
   int         frameEndCnt = 0;
   logic [7:0] expQ[$];

   cam_frame_ctrl #(
      .XCLK_DIV(2), .PWDN_CYC(4), .RST_CYC(4), .SETTLE_CYC(8),
      .LINE_START(1), .LINE_COUNT(2), .BYTE_START(2), .BYTE_COUNT(3)
   ) dut (
      .xipMCLK(clock), .xipRESET(reset), .iCAPTURE(iCAPTURE),
      .iCAM_VSYNC(iCAM_VSYNC), .iCAM_HREF(iCAM_HREF), .iCAM_PCLK(iCAM_PCLK), .iCAM_D(iCAM_D),
      .oCAM_PWDN(oCAM_PWDN), .onCAM_RESET(onCAM_RESET), .oCAM_XCLK(oCAM_XCLK),
      .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY),
      .oLINE_END(oLINE_END), .oFRAME_END(oFRAME_END), .oCAM_RDY(oCAM_RDY),
      .oBUSY(oBUSY), .oOVERFLOW(oOVERFLOW), .oTRUNC(oTRUNC), .oSTATE(oSTATE)
   );

   always #5 clock = ~clock;

   // Scoreboard consumer: every accepted byte is popped and compared.
   task automatic monitorLoop();
      logic [7:0] expByte;
      forever begin
         @(negedge clock);
         if (oLINE_END) lineEndCnt++;
         if (oFRAME_END) frameEndCnt++;
         if (!reset && oVALID && iREADY) begin
            testsRun++;
            if (expQ.size() == 0) begin
               testsFailed++;
               $display("[TB] FAIL stream_byte: got 0x%02h, required no byte", oDATA);
            end else begin
               expByte = expQ.pop_front();
               if (oDATA !== expByte) begin
                  testsFailed++;
                  $display("[TB] FAIL stream_byte: got 0x%02h, required 0x%02h", oDATA, expByte);
               end
            end
         end
      end
   endtask

   task automatic setReady(input logic v);
      @(posedge clock);
      #1 iREADY = v;
   endtask

   task automatic startCapture();
      @(negedge clock);
      iCAPTURE = 1'b1;
      @(negedge clock);
      iCAPTURE = 1'b0;
   endtask

   task automatic pushNormalWindow();
      for (int l = 1; l <= 2; l++)
         for (int b = 2; b <= 4; b++)
            expQ.push_back(8'(l * 16 + b));
   endtask

   // Sensor model: VSYNC low brackets the frame, 6 bytes per line, PCLK = MCLK/8.
   task automatic runFrame(input int nLines);
      iCAM_VSYNC = 1'b1;
      repeat (8) @(negedge clock);
      iCAM_VSYNC = 1'b0;
      repeat (8) @(negedge clock);
      for (int l = 0; l < nLines; l++) begin
         iCAM_HREF = 1'b1;
         for (int b = 0; b < 6; b++) begin
            iCAM_D = 8'(l * 16 + b);
            iCAM_PCLK = 1'b0;
            repeat (4) @(negedge clock);
            iCAM_PCLK = 1'b1;
            repeat (4) @(negedge clock);
         end
         iCAM_PCLK = 1'b0;
         iCAM_HREF = 1'b0;
         iCAM_D = 8'h00;
         repeat (16) @(negedge clock);
      end
      iCAM_VSYNC = 1'b1;
      repeat (16) @(negedge clock);
   endtask

   task automatic waitCaptureState(output bit found);
      int n = 0;
      while (oSTATE !== 3'd5 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      found = (oSTATE === 3'd5);
   endtask

   // Releases reset and times each power-up phase plus the XCLK period.
   task automatic checkPowerUp(input bit pokeCapture);
      int n;
      bit bad;
      int rises, first, period;
      logic prev;
      @(negedge clock);
      reset = 1'b0;
      n = 0; bad = 0;
      while (oSTATE === 3'd0 && n < 100) begin
         if (oCAM_PWDN !== 1'b1 || onCAM_RESET !== 1'b0 || oCAM_XCLK !== 1'b0) bad = 1;
         n++;
         @(negedge clock);
      end
      testsRun++;
      if (n != 4 || bad) begin
         testsFailed++;
         $display("[TB] FAIL pwdn_phase: got %0d cycles (pin error %0d), required 4 cycles", n, bad);
      end
      n = 0; bad = 0;
      while (oSTATE === 3'd1 && n < 100) begin
         if (oCAM_PWDN !== 1'b0 || onCAM_RESET !== 1'b0) bad = 1;
         n++;
         @(negedge clock);
      end
      testsRun++;
      if (n != 4 || bad) begin
         testsFailed++;
         $display("[TB] FAIL rst_phase: got %0d cycles (pin error %0d), required 4 cycles", n, bad);
      end
      n = 0; bad = 0;
      while (oSTATE === 3'd2 && n < 100) begin
         if (oCAM_PWDN !== 1'b0 || onCAM_RESET !== 1'b1 || oCAM_RDY !== 1'b0) bad = 1;
         iCAPTURE = (pokeCapture && n == 2);
         n++;
         @(negedge clock);
      end
      iCAPTURE = 1'b0;
      testsRun++;
      if (n != 8 || bad) begin
         testsFailed++;
         $display("[TB] FAIL settle_phase: got %0d cycles (pin error %0d), required 8 cycles", n, bad);
      end
      repeat (3) @(negedge clock);
      testsRun++;
      if (oSTATE !== 3'd3 || oCAM_RDY !== 1'b1 || oBUSY !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL ready_idle: got state %0d rdy %0b busy %0b, required state 3 rdy 1 busy 0",
                  oSTATE, oCAM_RDY, oBUSY);
      end
      rises = 0; first = 0; period = 0; n = 0;
      prev = oCAM_XCLK;
      while (rises < 2 && n < 50) begin
         @(negedge clock);
         n++;
         if (oCAM_XCLK && !prev) begin
            rises++;
            if (rises == 1) first = n;
            else period = n - first;
         end
         prev = oCAM_XCLK;
      end
      testsRun++;
      if (period != 4) begin
         testsFailed++;
         $display("[TB] FAIL xclk_period: got %0d MCLK, required 4 MCLK", period);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      testsRun++;
      if ({oCAM_PWDN, onCAM_RESET, oCAM_XCLK, oVALID, oLINE_END, oFRAME_END} !== 6'b100000) begin
         testsFailed++;
         $display("[TB] FAIL reset_pins: got %06b, required 100000",
                  {oCAM_PWDN, onCAM_RESET, oCAM_XCLK, oVALID, oLINE_END, oFRAME_END});
      end
      testsRun++;
      if ({oCAM_RDY, oBUSY, oOVERFLOW, oTRUNC, oSTATE, oDATA} !== 15'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_status: got rdy %0b busy %0b ovf %0b trunc %0b state %0d data 0x%02h, required all 0",
                  oCAM_RDY, oBUSY, oOVERFLOW, oTRUNC, oSTATE, oDATA);
      end
   endtask

   task automatic test_powerup();
      checkPowerUp(1'b1);
   endtask

   task automatic test_capture();
      int le0, fe0;
      setReady(1'b1);
      pushNormalWindow();
      le0 = lineEndCnt; fe0 = frameEndCnt;
      startCapture();
      testsRun++;
      if (oSTATE !== 3'd4 || oBUSY !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL capture_arm: got state %0d busy %0b, required state 4 busy 1", oSTATE, oBUSY);
      end
      runFrame(4);
      repeat (10) @(negedge clock);
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL capture_drain: got %0d bytes missing, required 0", expQ.size());
         expQ.delete();
      end
      testsRun++;
      if (lineEndCnt - le0 != 2 || frameEndCnt - fe0 != 1) begin
         testsFailed++;
         $display("[TB] FAIL capture_pulses: got %0d line ends %0d frame ends, required 2 and 1",
                  lineEndCnt - le0, frameEndCnt - fe0);
      end
      testsRun++;
      if (oOVERFLOW !== 1'b0 || oTRUNC !== 1'b0 || oSTATE !== 3'd3) begin
         testsFailed++;
         $display("[TB] FAIL capture_status: got ovf %0b trunc %0b state %0d, required 0 0 3",
                  oOVERFLOW, oTRUNC, oSTATE);
      end
   endtask

   task automatic test_backpressure();
      int fe0;
      setReady(1'b0);
      expQ.push_back(8'h12);
      fe0 = frameEndCnt;
      startCapture();
      runFrame(4);
      repeat (10) @(negedge clock);
      testsRun++;
      if (oVALID !== 1'b1 || oDATA !== 8'h12 || oOVERFLOW !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL bp_hold: got valid %0b data 0x%02h ovf %0b, required 1 0x12 1",
                  oVALID, oDATA, oOVERFLOW);
      end
      testsRun++;
      if (frameEndCnt - fe0 != 1 || oSTATE !== 3'd3) begin
         testsFailed++;
         $display("[TB] FAIL bp_done: got %0d frame ends state %0d, required 1 and 3", frameEndCnt - fe0, oSTATE);
      end
      setReady(1'b1);
      repeat (4) @(negedge clock);
      testsRun++;
      if (expQ.size() != 0 || oVALID !== 1'b0 || oOVERFLOW !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL bp_release: got pending %0d valid %0b ovf %0b, required 0 0 1",
                  expQ.size(), oVALID, oOVERFLOW);
         expQ.delete();
      end
      startCapture();
      testsRun++;
      if (oOVERFLOW !== 1'b0 || oSTATE !== 3'd4) begin
         testsFailed++;
         $display("[TB] FAIL bp_clear: got ovf %0b state %0d, required 0 and 4", oOVERFLOW, oSTATE);
      end
      pushNormalWindow();
      runFrame(4);
      repeat (10) @(negedge clock);
      testsRun++;
      if (expQ.size() != 0 || oSTATE !== 3'd3) begin
         testsFailed++;
         $display("[TB] FAIL bp_recover: got %0d bytes missing state %0d, required 0 and 3", expQ.size(), oSTATE);
         expQ.delete();
      end
   endtask

   task automatic test_truncation();
      int le0, fe0;
      setReady(1'b1);
      for (int b = 2; b <= 4; b++) expQ.push_back(8'(16 + b));
      le0 = lineEndCnt; fe0 = frameEndCnt;
      startCapture();
      runFrame(2);
      repeat (10) @(negedge clock);
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL trunc_drain: got %0d bytes missing, required 0", expQ.size());
         expQ.delete();
      end
      testsRun++;
      if (oTRUNC !== 1'b1 || oOVERFLOW !== 1'b0 || oSTATE !== 3'd3) begin
         testsFailed++;
         $display("[TB] FAIL trunc_status: got trunc %0b ovf %0b state %0d, required 1 0 3", oTRUNC, oOVERFLOW, oSTATE);
      end
      testsRun++;
      if (lineEndCnt - le0 != 1 || frameEndCnt - fe0 != 1) begin
         testsFailed++;
         $display("[TB] FAIL trunc_pulses: got %0d line ends %0d frame ends, required 1 and 1",
                  lineEndCnt - le0, frameEndCnt - fe0);
      end
   endtask

   task automatic test_ignore_capture();
      int fe0;
      bit found;
      pushNormalWindow();
      fe0 = frameEndCnt;
      startCapture();
      fork
         runFrame(4);
         begin
            waitCaptureState(found);
            repeat (10) @(negedge clock);
            iCAPTURE = 1'b1;
            @(negedge clock);
            iCAPTURE = 1'b0;
            testsRun++;
            if (!found || oSTATE !== 3'd5) begin
               testsFailed++;
               $display("[TB] FAIL ignore_in_capture: got state %0d (reached %0b), required 5", oSTATE, found);
            end
         end
      join
      repeat (10) @(negedge clock);
      testsRun++;
      if (expQ.size() != 0 || frameEndCnt - fe0 != 1) begin
         testsFailed++;
         $display("[TB] FAIL ignore_frame: got %0d missing %0d frame ends, required 0 and 1",
                  expQ.size(), frameEndCnt - fe0);
         expQ.delete();
      end
      fe0 = frameEndCnt;
      runFrame(4);
      repeat (10) @(negedge clock);
      testsRun++;
      if (oSTATE !== 3'd3 || frameEndCnt != fe0) begin
         testsFailed++;
         $display("[TB] FAIL no_second_capture: got state %0d %0d extra frame ends, required 3 and 0",
                  oSTATE, frameEndCnt - fe0);
      end
   endtask

   task automatic test_reset_mid_capture();
      bit found;
      setReady(1'b1);
      startCapture();
      fork
         runFrame(4);
         begin
            waitCaptureState(found);
            repeat (20) @(negedge clock);
            reset = 1'b1;
            #1;
            testsRun++;
            if (!found || oVALID !== 1'b0 || oSTATE !== 3'd0 || oCAM_PWDN !== 1'b1 || onCAM_RESET !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL mid_reset: got valid %0b state %0d pwdn %0b nrst %0b (reached %0b), required 0 0 1 0",
                        oVALID, oSTATE, oCAM_PWDN, onCAM_RESET, found);
            end
            checkPowerUp(1'b0);
         end
      join
      repeat (10) @(negedge clock);
      testsRun++;
      if (oSTATE !== 3'd3 || oVALID !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL post_reset_idle: got state %0d valid %0b, required 3 and 0", oSTATE, oVALID);
      end
   endtask

   initial begin
      fork
         monitorLoop();
         begin
            test_reset();
            test_powerup();
            test_capture();
            test_backpressure();
            test_truncation();
            test_ignore_capture();
            test_reset_mid_capture();
            $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
            $finish;
         end
      join
   end

endmodule
